// File: rtl/gcn_aggregate_argmax.sv
// GCN neighbour aggregation over a COO edge list followed by a per-node argmax.
// It takes a snapshot of the transformed matrix, accumulates one edge per cycle, and then scores one row per cycle.
module gcn_aggregate_argmax #(
    parameter int unsigned FEATURE_ROWS      = 6,
    parameter int unsigned WEIGHT_COLS       = 3,
    parameter int unsigned DOT_PROD_WIDTH    = 16,
    parameter int unsigned COO_NUM_OF_COLS   = 6,
    parameter int unsigned COO_BW            = $clog2(COO_NUM_OF_COLS),
    parameter int unsigned MAX_ADDRESS_WIDTH = 2,
    parameter int unsigned AGG_WIDTH         = DOT_PROD_WIDTH + 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DOT_PROD_WIDTH-1:0]    fm_wm_in [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1],
    output logic [COO_BW-1:0]            coo_address,
    input  logic [2*COO_BW-1:0]          coo_in,
    output logic                         done,
    output logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FEATURE_ROWS-1]
);

    localparam int unsigned ROW_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
    localparam int unsigned ID_W  = COO_BW + 1;

    typedef enum logic [2:0] {IDLE, LOAD, EDGE, ARGMAX, DONE} state_t;

    state_t state;
    state_t next_state;

    logic [DOT_PROD_WIDTH-1:0]    fw  [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];
    logic [AGG_WIDTH-1:0]         acc [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];
    logic [ROW_W-1:0]             row_idx;

    logic [COO_BW-1:0]            src_id;
    logic [COO_BW-1:0]            dst_id;
    logic [COO_BW-1:0]            src_row;
    logic [COO_BW-1:0]            dst_row;
    logic                         edge_valid;
    logic                         edge_self;

    logic [AGG_WIDTH-1:0]         best_val;
    logic [MAX_ADDRESS_WIDTH-1:0] best_idx;

    // Edge decode: ids are 1-based; any out-of-range id drops the whole edge.
    always_comb begin
        src_id     = coo_in[2*COO_BW-1:COO_BW];
        dst_id     = coo_in[COO_BW-1:0];
        src_row    = src_id - COO_BW'(1);
        dst_row    = dst_id - COO_BW'(1);
        edge_valid = (src_id != '0) && (dst_id != '0)
                  && (ID_W'(src_id) <= ID_W'(FEATURE_ROWS))
                  && (ID_W'(dst_id) <= ID_W'(FEATURE_ROWS));
        edge_self  = (src_id == dst_id);
    end

    // Argmax of the current row; strict compare keeps the lowest column on ties.
    always_comb begin
        best_val = acc[row_idx][0];
        best_idx = '0;
        for (int unsigned c = 1; c < WEIGHT_COLS; c++) begin
            if (acc[row_idx][c] > best_val) begin
                best_val = acc[row_idx][c];
                best_idx = MAX_ADDRESS_WIDTH'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = EDGE;
            EDGE:    if (coo_address == COO_BW'(COO_NUM_OF_COLS - 1)) next_state = ARGMAX;
            ARGMAX:  if (row_idx == ROW_W'(FEATURE_ROWS - 1)) next_state = DONE;
            DONE:    if (!start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done        <= 1'b0;
            coo_address <= '0;
            row_idx     <= '0;
            for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
                max_addi_answer[r] <= '0;
                for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
                    fw[r][c]  <= '0;
                    acc[r][c] <= '0;
                end
            end
        end else begin
            done <= (next_state == DONE);
            case (state)
                LOAD: begin
                    coo_address <= '0;
                    row_idx     <= '0;
                    for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
                        for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
                            fw[r][c]  <= fm_wm_in[r][c];
                            acc[r][c] <= '0;
                        end
                    end
                end
                EDGE: begin
                    coo_address <= (next_state == EDGE) ? coo_address + COO_BW'(1) : '0;
                    // Symmetric update; a self-loop contributes its own row once.
                    if (edge_valid) begin
                        for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
                            if (edge_self) begin
                                acc[src_row][c] <= acc[src_row][c] + AGG_WIDTH'(fw[src_row][c]);
                            end else begin
                                acc[dst_row][c] <= acc[dst_row][c] + AGG_WIDTH'(fw[src_row][c]);
                                acc[src_row][c] <= acc[src_row][c] + AGG_WIDTH'(fw[dst_row][c]);
                            end
                        end
                    end
                end
                ARGMAX: begin
                    coo_address              <= '0;
                    max_addi_answer[row_idx] <= best_idx;
                    row_idx                  <= row_idx + ROW_W'(1);
                end
                default: begin
                    coo_address <= '0;
                    row_idx     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/gcn_aggregate_argmax.md
GCN_AGGREGATE_ARGMAX -- requirements
Module: gcn_aggregate_argmax

Interface
REQ-001 Parameter FEATURE_ROWS, default 6: number of graph nodes, which is also the number of rows in the transformed matrix.
REQ-002 Parameter WEIGHT_COLS, default 3: number of output classes, which is also the number of columns in the transformed matrix.
REQ-003 Parameter DOT_PROD_WIDTH, default 16: unsigned width of each transformed element.
REQ-004 Parameter COO_NUM_OF_COLS, default 6: number of edges in the COO list.
REQ-005 Parameter COO_BW, default $clog2(COO_NUM_OF_COLS): width of the edge index and of each node id.
REQ-006 Parameter MAX_ADDRESS_WIDTH, default 2: width of each argmax result.
REQ-007 Parameter AGG_WIDTH, default DOT_PROD_WIDTH+4: width of the internal accumulator.
REQ-008 clk  in  1  the single clock; all state updates on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 start  in  1  run request; level-sensitive.
REQ-011 fm_wm_in  in  [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1] x DOT_PROD_WIDTH  transformed matrix (FM x WM); stable while start is high.
REQ-012 coo_address  out  COO_BW  registered edge index.
REQ-013 coo_in  in  2*COO_BW  {src, dst} node ids (1-based); driven combinationally from coo_address in the same cycle.
REQ-014 done  out  1  results valid.
REQ-015 max_addi_answer  out  [0:FEATURE_ROWS-1] x MAX_ADDRESS_WIDTH  per-node argmax class.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, EDGE, ARGMAX and DONE.
REQ-017 Transition IDLE->LOAD on start=1; in LOAD, snapshot fm_wm_in into local registers and clear all accumulators to 0.
REQ-018 Transition LOAD->EDGE with coo_address=0; in EDGE, process one edge per cycle, using coo_in as sampled at the edge where coo_address=e.
REQ-019 Edge {s,d} with 1<=s,d<=FEATURE_ROWS and s!=d: acc[d-1][c] += fw[s-1][c] and acc[s-1][c] += fw[d-1][c], for all columns c, in the same cycle.
REQ-020 Self-edge s==d (valid id): acc[s-1][c] += fw[s-1][c], applied exactly once.
REQ-021 Edge with any id equal to 0 or greater than FEATURE_ROWS: skipped, with no accumulator change.
REQ-022 Edge index: coo_address increments by 1 per cycle; after edge COO_NUM_OF_COLS-1, transition EDGE->ARGMAX and coo_address returns to 0.
REQ-023 Arithmetic: all sums are unsigned at AGG_WIDTH, with no truncation and no saturation; comparisons use the full AGG_WIDTH.
REQ-024 ARGMAX: process one row per cycle, rows 0..FEATURE_ROWS-1; max_addi_answer[r] = index of the largest acc[r][c].
REQ-025 Ties: the lowest column index wins; a row of all zeros yields 0.
REQ-026 Transition ARGMAX->DONE after row FEATURE_ROWS-1.
REQ-027 done is 1 exactly while in DONE.
REQ-028 Transition DONE->IDLE when start=0; start held high keeps the FSM in DONE with no restart.
REQ-029 Latency: start sampled high in IDLE at edge t0 -> done=1 after edge t0+1+COO_NUM_OF_COLS+FEATURE_ROWS (t0+13 at defaults).
REQ-030 start changes while in LOAD, EDGE or ARGMAX SHALL be ignored.
REQ-031 max_addi_answer holds its value in DONE and IDLE until it is overwritten by the next run's ARGMAX.
REQ-032 coo_address SHALL be 0 in every state other than EDGE.

Reset
REQ-033 reset=1 at a rising edge forces IDLE: done=0, coo_address=0, all max_addi_answer=0, accumulators and snapshot cleared.
REQ-034 Reset has priority over all other inputs and SHALL abort a run in progress with no partial result retained.
REQ-035 The first run after reset behaves identically to a run from power-up.

Verification
REQ-036 Basic run: fw0=[10,20,5], fw1=[30,1,2], fw2=[0,0,7], fw3..5=0; edges (1,2),(2,3), remaining four edges (0,0) -> max_addi_answer=[0,1,0,0,0,0], done at t0+13, coo_address sweeps 0..5.
REQ-037 Tie and self-loop: fw0=[5,5,5], fw3=[1,2,9], other rows 0; edges (2,1),(4,4), rest (0,0) -> row1=0 (tie), row3=2, row0=0.
REQ-038 Width: fw0=0; fw1=[0xFFFF,0xC000,0]; fw2..5=[0,0xC000,0]; edges (1,2),(1,3),(1,4),(1,5),(1,6),(1,2) -> acc0=[0x1FFFE,0x48000,0], row0=1 (a truncating implementation gives 0).
REQ-039 Start held: start kept at 1 after done -> done stays 1, no second sweep of coo_address; drop start for 1 cycle then raise it again -> a new run completes at +13 with identical results.
REQ-040 Reset mid-run: assert reset for 1 cycle while coo_address=3 -> next edge gives done=0, coo_address=0 and all answers 0; a fresh start with the REQ-036 data reproduces the REQ-036 results.
REQ-041 All-invalid edges: every edge (7,0) -> all answers 0 and done at t0+13.
